sparc_exu_div_iter: RTL and testbench

- Iterative 64/32 divide engine for UDIV/SDIV in the EXU.
- Sits directly downstream of the per-thread Y register file. It consumes the selected thread's Y value (yreg_mdq_y_e) as the high dividend word, and rs1 as the low word.
- Produces a 32-bit saturated quotient, an overflow flag, a divide-by-zero flag and the owning thread id, for writeback and condition-code logic.
- Uses a one-bit-per-cycle restoring algorithm on magnitudes, with sign fix-up at the end.

---
 rtl/sparc_exu_div_pkg.sv | 25 ++
 rtl/sparc_exu_div_step.sv | 25 ++
 rtl/sparc_exu_div_iter.sv | 206 ++++++++++++++++++++
 tb/tb_sparc_exu_div_iter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_div_pkg.sv
// Shared types and constants for the iterative 64/32 EXU divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sparc_exu_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  localparam int DIV_ITERS = 32;

  localparam logic [31:0] UDIV_SAT     = 32'hFFFF_FFFF;
  localparam logic [31:0] SDIV_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] SDIV_NEG_SAT = 32'h8000_0000;

  // Two's complement negate, used for magnitudes and the sign fix-up.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/sparc_exu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every ITER cycle by the parent.
module sparc_exu_div_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // Trial subtraction; the difference only needs 33 bits when it is kept.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    ge      = (shifted >= {2'b00, divisor});
    diff    = shifted[32:0] - {1'b0, divisor};
    q_bit   = ge;
    rem_out = ge ? diff : shifted[32:0];
  end

endmodule

// File: rtl/sparc_exu_div_iter.sv
// Iterative 64/32 UDIV/SDIV engine with saturation, overflow and zero-divisor flags.
// Latency: done pulse 35 cycles after start (3 on pre-overflow, 2 on zero divisor).
// Backpressure: none; issue must hold off while div_busy, a start while busy is ignored.
module sparc_exu_div_iter
  import sparc_exu_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int THR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [THR_W-1:0]  div_thr,
  input  logic [DATA_W-1:0] yreg_mdq_y_e,
  input  logic [DATA_W-1:0] div_rs1_data,
  input  logic [DATA_W-1:0] div_rs2_data,
  input  logic              div_kill,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result,
  output logic              div_ovf,
  output logic              div_zero,
  output logic [THR_W-1:0]  div_thr_out
);

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  div_state_e state, state_nxt;

  // Captured operands
  logic              op_sgn;
  logic [THR_W-1:0]  op_thr;
  logic [31:0]       op_y;
  logic [31:0]       op_a;
  logic [31:0]       op_b;

  // Iteration datapath
  logic [32:0]       rem;
  logic [31:0]       dvd_lo;
  logic [31:0]       dvs;
  logic [31:0]       quo;
  logic [4:0]        cnt;
  logic              res_neg;
  logic              pre_ovf;

  // Result staged until DONE so an abort never disturbs the visible outputs
  logic [31:0]       res_pend;
  logic              ovf_pend;
  logic              zero_pend;

  // Magnitudes formed from the captured operands
  logic [63:0]       dvd_full;
  logic [63:0]       dvd_mag;
  logic [31:0]       dvs_mag;
  logic              dvd_neg;
  logic              dvs_neg;
  logic              dvs_is_zero;
  logic              hi_ovf;

  logic [32:0]       step_rem;
  logic              step_q;

  sparc_exu_div_step u_step (
    .rem_in  (rem),
    .dvd_bit (dvd_lo[31]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign detection, magnitudes and the early-out conditions evaluated in CHECK
  always_comb begin
    dvd_full    = {op_y, op_a};
    dvd_neg     = op_sgn & op_y[31];
    dvs_neg     = op_sgn & op_b[31];
    dvd_mag     = dvd_neg ? ((~dvd_full) + 64'd1) : dvd_full;
    dvs_mag     = dvs_neg ? neg32(op_b) : op_b;
    dvs_is_zero = (op_b == 32'd0);
    hi_ovf      = (dvd_mag[63:32] >= dvs_mag);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; kill returns any busy state to IDLE and beats a start
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (div_start && !div_kill) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (dvs_is_zero)  state_nxt = ST_DONE;
        else if (hi_ovf)  state_nxt = ST_FIX;
        else              state_nxt = ST_ITER;
      end
      ST_ITER:  if (cnt == LAST_CNT) state_nxt = ST_FIX;
      ST_FIX:   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && div_kill) state_nxt = ST_IDLE;
  end

  assign div_busy = (state != ST_IDLE);

  // Operand capture in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sgn <= 1'b0;
      op_thr <= '0;
      op_y   <= 32'd0;
      op_a   <= 32'd0;
      op_b   <= 32'd0;
    end else if (state == ST_IDLE && div_start && !div_kill) begin
      op_sgn <= div_signed;
      op_thr <= div_thr;
      op_y   <= yreg_mdq_y_e;
      op_a   <= div_rs1_data;
      op_b   <= div_rs2_data;
    end
  end

  // Datapath: set up magnitudes in CHECK, one quotient bit per ITER cycle, sign fix-up in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= 33'd0;
      dvd_lo    <= 32'd0;
      dvs       <= 32'd0;
      quo       <= 32'd0;
      cnt       <= 5'd0;
      res_neg   <= 1'b0;
      pre_ovf   <= 1'b0;
      res_pend  <= 32'd0;
      ovf_pend  <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      unique case (state)
        ST_CHECK: begin
          rem       <= {1'b0, dvd_mag[63:32]};
          dvd_lo    <= dvd_mag[31:0];
          dvs       <= dvs_mag;
          quo       <= 32'd0;
          cnt       <= 5'd0;
          res_neg   <= dvd_neg ^ dvs_neg;
          pre_ovf   <= hi_ovf & ~dvs_is_zero;
          zero_pend <= dvs_is_zero;
          res_pend  <= 32'd0;
          ovf_pend  <= 1'b0;
        end
        ST_ITER: begin
          rem    <= step_rem;
          dvd_lo <= {dvd_lo[30:0], 1'b0};
          quo    <= {quo[30:0], step_q};
          cnt    <= cnt + 5'd1;
        end
        ST_FIX: begin
          if (!op_sgn) begin
            res_pend <= pre_ovf ? UDIV_SAT : quo;
            ovf_pend <= pre_ovf;
          end else if (!res_neg) begin
            if (pre_ovf || quo > SDIV_POS_SAT) begin
              res_pend <= SDIV_POS_SAT;
              ovf_pend <= 1'b1;
            end else begin
              res_pend <= quo;
              ovf_pend <= 1'b0;
            end
          end else begin
            if (pre_ovf || quo > SDIV_NEG_SAT) begin
              res_pend <= SDIV_NEG_SAT;
              ovf_pend <= 1'b1;
            end else begin
              res_pend <= neg32(quo);
              ovf_pend <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers: committed from DONE unless killed; done is a one-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done    <= 1'b0;
      div_result  <= '0;
      div_ovf     <= 1'b0;
      div_zero    <= 1'b0;
      div_thr_out <= '0;
    end else begin
      div_done <= 1'b0;
      if (state == ST_DONE && !div_kill) begin
        div_done    <= 1'b1;
        div_result  <= res_pend;
        div_ovf     <= ovf_pend;
        div_zero    <= zero_pend;
        div_thr_out <= op_thr;
      end
    end
  end

endmodule

// File: tb/tb_sparc_exu_div_iter.sv
module tb_sparc_exu_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [1:0]  div_thr = 2'd0;
  logic [31:0] yreg_mdq_y_e = 32'd0;
  logic [31:0] div_rs1_data = 32'd0;
  logic [31:0] div_rs2_data = 32'd0;
  logic        div_kill = 1'b0;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;
  logic        div_ovf;
  logic        div_zero;
  logic [1:0]  div_thr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sparc_exu_div_iter #(.DATA_W(32), .THR_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_thr      (div_thr),
    .yreg_mdq_y_e (yreg_mdq_y_e),
    .div_rs1_data (div_rs1_data),
    .div_rs2_data (div_rs2_data),
    .div_kill     (div_kill),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_result   (div_result),
    .div_ovf      (div_ovf),
    .div_zero     (div_zero),
    .div_thr_out  (div_thr_out)
  );

  // Issue one operation and count edges after the start edge until done (bounded).
  task automatic do_op(input logic sgn, input logic [1:0] thr, input logic [31:0] y,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    div_signed   = sgn;
    div_thr      = thr;
    yreg_mdq_y_e = y;
    div_rs1_data = a;
    div_rs2_data = b;
    div_start    = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    lat = 0;
    while (!div_done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (div_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %0b want 0", div_busy); end
    checks++; if (div_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %0b want 0", div_done); end
    checks++; if (div_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", div_result); end
    checks++; if (div_ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %0b want 0", div_ovf); end
    checks++; if (div_zero !== 1'b0)    begin errors++; $display("FAIL reset_zero got %0b want 0", div_zero); end
    checks++; if (div_thr_out !== 2'd0) begin errors++; $display("FAIL reset_thr got %0d want 0", div_thr_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_udiv_basic();
    int lat;
    do_op(1'b0, 2'd2, 32'd0, 32'd100, 32'd7, lat);
    checks++; if (lat != 35)             begin errors++; $display("FAIL udiv_latency got %0d want 35", lat); end
    checks++; if (div_result !== 32'd14) begin errors++; $display("FAIL udiv_result got %h want 0000000e", div_result); end
    checks++; if (div_ovf !== 1'b0)      begin errors++; $display("FAIL udiv_ovf got %0b want 0", div_ovf); end
    checks++; if (div_zero !== 1'b0)     begin errors++; $display("FAIL udiv_zero got %0b want 0", div_zero); end
    checks++; if (div_thr_out !== 2'd2)  begin errors++; $display("FAIL udiv_thr got %0d want 2", div_thr_out); end
    @(posedge clk);
    #1;
    checks++; if (div_done !== 1'b0)     begin errors++; $display("FAIL udiv_done_pulse got %0b want 0", div_done); end
    checks++; if (div_result !== 32'd14) begin errors++; $display("FAIL udiv_hold got %h want 0000000e", div_result); end
    do_op(1'b0, 2'd3, 32'd0, 32'hFFFF_FFFF, 32'h0001_0000, lat);
    checks++; if (div_result !== 32'h0000_FFFF) begin errors++; $display("FAIL udiv_big got %h want 0000ffff", div_result); end
    do_op(1'b0, 2'd0, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, lat);
    checks++; if (div_result !== 32'd0)  begin errors++; $display("FAIL udiv_small got %h want 0", div_result); end
  endtask

  task automatic test_udiv_preovf();
    int lat;
    do_op(1'b0, 2'd1, 32'd1, 32'd0, 32'd1, lat);
    checks++; if (lat != 3)                     begin errors++; $display("FAIL preovf_latency got %0d want 3", lat); end
    checks++; if (div_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL preovf_result got %h want ffffffff", div_result); end
    checks++; if (div_ovf !== 1'b1)             begin errors++; $display("FAIL preovf_ovf got %0b want 1", div_ovf); end
  endtask

  task automatic test_sdiv();
    logic [31:0] ty[5];
    logic [31:0] ta[5];
    logic [31:0] tb[5];
    logic [31:0] tr[5];
    logic        to[5];
    int lat;
    ty[0] = 32'hFFFF_FFFF; ta[0] = 32'hFFFF_FF9C; tb[0] = 32'd7;          tr[0] = 32'hFFFF_FFF2; to[0] = 1'b0;
    ty[1] = 32'd0;         ta[1] = 32'h8000_0000; tb[1] = 32'd1;          tr[1] = 32'h7FFF_FFFF; to[1] = 1'b1;
    ty[2] = 32'hFFFF_FFFF; ta[2] = 32'h8000_0000; tb[2] = 32'd1;          tr[2] = 32'h8000_0000; to[2] = 1'b0;
    ty[3] = 32'hFFFF_FFFF; ta[3] = 32'h8000_0000; tb[3] = 32'hFFFF_FFFF;  tr[3] = 32'h7FFF_FFFF; to[3] = 1'b1;
    ty[4] = 32'd0;         ta[4] = 32'd100;       tb[4] = 32'hFFFF_FFF9;  tr[4] = 32'hFFFF_FFF2; to[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 2'(i), ty[i], ta[i], tb[i], lat);
      checks++; if (div_done !== 1'b1) begin errors++; $display("FAIL sdiv%0d_done got %0b want 1", i, div_done); end
      checks++; if (div_result !== tr[i]) begin errors++; $display("FAIL sdiv%0d_result got %h want %h", i, div_result, tr[i]); end
      checks++; if (div_ovf !== to[i]) begin errors++; $display("FAIL sdiv%0d_ovf got %0b want %0b", i, div_ovf, to[i]); end
    end
  endtask

  task automatic test_zero_divisor();
    int lat;
    for (int s = 0; s < 2; s++) begin
      do_op(1'(s), 2'd3, 32'd0, 32'd55, 32'd0, lat);
      checks++; if (lat != 2)             begin errors++; $display("FAIL zero%0d_latency got %0d want 2", s, lat); end
      checks++; if (div_zero !== 1'b1)    begin errors++; $display("FAIL zero%0d_flag got %0b want 1", s, div_zero); end
      checks++; if (div_result !== 32'd0) begin errors++; $display("FAIL zero%0d_result got %h want 0", s, div_result); end
      checks++; if (div_thr_out !== 2'd3) begin errors++; $display("FAIL zero%0d_thr got %0d want 3", s, div_thr_out); end
    end
    do_op(1'b0, 2'd1, 32'd0, 32'd50, 32'd5, lat);
    checks++; if (lat != 35)             begin errors++; $display("FAIL after_zero_latency got %0d want 35", lat); end
    checks++; if (div_result !== 32'd10) begin errors++; $display("FAIL after_zero_result got %h want 0000000a", div_result); end
    checks++; if (div_zero !== 1'b0)     begin errors++; $display("FAIL after_zero_flag got %0b want 0", div_zero); end
  endtask

  task automatic test_kill_iter();
    int seen = 0;
    @(negedge clk);
    div_signed = 1'b0; div_thr = 2'd2;
    yreg_mdq_y_e = 32'd0; div_rs1_data = 32'd1000; div_rs2_data = 32'd3;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    div_kill = 1'b1;
    @(posedge clk);
    #1;
    div_kill = 1'b0;
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %0b want 0", div_busy); end
    for (int i = 0; i < 40; i++) begin
      if (div_done) seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen != 0)             begin errors++; $display("FAIL kill_no_done got %0d pulses want 0", seen); end
    checks++; if (div_result !== 32'd10) begin errors++; $display("FAIL kill_retain_result got %h want 0000000a", div_result); end
    checks++; if (div_thr_out !== 2'd1)  begin errors++; $display("FAIL kill_retain_thr got %0d want 1", div_thr_out); end
  endtask

  task automatic test_start_kill_idle();
    int seen = 0;
    @(negedge clk);
    div_rs1_data = 32'd9; div_rs2_data = 32'd3;
    div_start = 1'b1;
    div_kill  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    div_kill  = 1'b0;
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL startkill_busy got %0b want 0", div_busy); end
    for (int i = 0; i < 5; i++) begin
      if (div_done || div_busy) seen++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL startkill_activity got %0d want 0", seen); end
  endtask

  task automatic test_rst_mid_iter();
    int lat;
    @(negedge clk);
    div_signed = 1'b0; div_thr = 2'd3;
    yreg_mdq_y_e = 32'd0; div_rs1_data = 32'd1000; div_rs2_data = 32'd3;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %0b want 1", div_busy); end
    rst = 1'b1;
    #1;
    checks++; if (div_busy !== 1'b0)    begin errors++; $display("FAIL rst_async_busy got %0b want 0", div_busy); end
    checks++; if (div_result !== 32'd0) begin errors++; $display("FAIL rst_async_result got %h want 0", div_result); end
    checks++; if (div_thr_out !== 2'd0) begin errors++; $display("FAIL rst_async_thr got %0d want 0", div_thr_out); end
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 2'd2, 32'd0, 32'd1000, 32'd3, lat);
    checks++; if (lat != 35)              begin errors++; $display("FAIL post_rst_latency got %0d want 35", lat); end
    checks++; if (div_result !== 32'd333) begin errors++; $display("FAIL post_rst_result got %h want 0000014d", div_result); end
  endtask

  initial begin
    test_reset();
    test_udiv_basic();
    test_udiv_preovf();
    test_sdiv();
    test_zero_divisor();
    test_kill_iter();
    test_start_kill_idle();
    test_rst_mid_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
